wots_chain_engine: RTL and testbench
====================================

Name: wots_chain_engine

Overview:
- Responder side of the WOTS chain interface: takes a chain request (start key/data, step range, hash address) and runs the XMSS chaining function F over steps [start_step, end_step).
- Drives the shared SHA-256 hash-core request interface and returns the chain result plus the updated hash address.
- Sits beside the leaf/pk generators as the single chain engine; its hash requests are muxed upstream onto the hash core.

Parameters:
- WOTS_W, 16, Winternitz parameter.
- WOTS_LOG_W, CLOG2(WOTS_W), step field width.
- KEY_LEN, 256, key/data width n*8.
- XMSS_HASH_PADDING_F, 0, domain-separation prefix for F.
- XMSS_HASH_PADDING_PRF, 3, domain-separation prefix for PRF.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request pulse.
- input_key  in  KEY_LEN  public seed.
- input_data  in  KEY_LEN  chain start value.
- start_step  in  WOTS_LOG_W  first step index.
- end_step  in  WOTS_LOG_W  exclusive end step.
- hash_addr  in  256  address; word k = bits [255-32k -: 32].
- data_out  out  KEY_LEN  chain result.
- done  out  1  one-cycle completion pulse.
- busy  out  1  request in progress.
- hash_addr_updated  out  256  final address.
- hash_start  out  1  one-cycle hash request.
- hash_data_in  out  1024  message, MSB-aligned.
- message_length  out  1  0 = 768-bit message, 1 = 1024-bit; always 0.
- store_intermediate  out  1  core saves state after the first 512-bit block.
- continue_intermediate  out  1  core resumes from saved state and hashes only the second block.
- hash_done  in  1  one-cycle result valid.
- hash_data_out  in  KEY_LEN  digest.

Behaviour:
- Reset (async): state IDLE; data_out, hash_addr_updated, hash_data_in = 0; done, busy, hash_start, store_intermediate, continue_intermediate = 0.
- IDLE: on start, latch all inputs. Set step i = start_step and cur = input_data. Set busy = 1 and go to CHECK. start while busy is ignored.
- CHECK: if i >= end_step, go to FIN. Otherwise set addr word6 = i, word7 = 0, and go to REQ_KEY.
- REQ_KEY: pulse hash_start with {256'(PRF pad), input_key, addr, 256'd0}, then go to WAIT_KEY.
- WAIT_KEY: on hash_done, key = hash_data_out, set word7 = 1, go to REQ_MASK.
- REQ_MASK: same message format as REQ_KEY, with word7 = 1. Pulse hash_start, then go to WAIT_MASK.
- WAIT_MASK: on hash_done, mask = hash_data_out, go to REQ_F.
- REQ_F: pulse hash_start with {256'(F pad), key, cur ^ mask, 256'd0}, then go to WAIT_F.
- WAIT_F: on hash_done, cur = hash_data_out and i = i + 1. If i was WOTS_W-1 before the increment, the step range is saturated: go to FIN. Otherwise go to CHECK.
- Intermediate flags:
  - store_intermediate = 1 with the first PRF hash_start of a request.
  - continue_intermediate = 1 with every later PRF hash_start of the same request, since the first block {PRF pad, input_key} is constant per request.
  - Both are 0 on F requests.
- FIN: data_out = cur and hash_addr_updated = addr. Pulse done for exactly 1 cycle, with busy = 0 in the same cycle. Return to IDLE.
- Zero-step request (start_step >= end_step):
  - done 2 cycles after start.
  - data_out = input_data.
  - hash_addr_updated = hash_addr unchanged.
  - no hash_start.
- Nonzero request: exactly 3*(end_step - start_step) hash_start pulses. Final word6 = end_step-1, word7 = 1. All other address words are passed through untouched.
- hash_done outside the WAIT_* states is ignored; hash_start is never asserted while a request is outstanding.
- data_out and hash_addr_updated hold their values until the next FIN.
- Reset mid-operation aborts immediately with no done. A hash_done arriving after reset release is ignored.

Test Plan:
- start_step=3, end_step=3, input_data=0xA5..A5: done at cycle start+2, data_out=0xA5..A5, 0 hash_start pulses, hash_addr_updated==hash_addr.
- start_step=0, end_step=1, hash model returns K, M, F in order:
  - hash_data_in fields are correct, with word6=0 and word7=0 then 1.
  - F payload = cur^M.
  - store_intermediate only on the first request.
  - data_out=F, 3 pulses.
- start_step=0, end_step=15:
  - 45 hash_start pulses, word6 sequence 0..14.
  - continue_intermediate on 29 PRFs.
  - final word6=14, word7=1.
- hash_done delayed 1 vs 80 cycles: identical data_out; start pulsed mid-chain is ignored; spurious hash_done in IDLE is ignored.
- Assert reset during WAIT_MASK: all outputs 0 at once. A late hash_done after release has no effect; next request completes normally.
- Words 0-5 of hash_addr = 0x11111111..0x66666666: preserved in hash_addr_updated and in every PRF address.

Source files
------------

// File: rtl/wots_chain_engine.sv
`default_nettype none
// ============================================================================
// Module   : wots_chain_engine
// Brief    : WOTS chaining-function engine; runs F over [start_step, end_step)
//            using the shared SHA-256 core (PRF key, PRF mask, F per step).
// Revision : 1.0 - initial release
// ============================================================================
module wots_chain_engine #(
    parameter int WOTS_W                = 16,
    parameter int WOTS_LOG_W            = $clog2(WOTS_W),
    parameter int KEY_LEN               = 256,
    parameter int XMSS_HASH_PADDING_F   = 0,
    parameter int XMSS_HASH_PADDING_PRF = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [KEY_LEN-1:0]    input_key,
    input  logic [KEY_LEN-1:0]    input_data,
    input  logic [WOTS_LOG_W-1:0] start_step,
    input  logic [WOTS_LOG_W-1:0] end_step,
    input  logic [255:0]          hash_addr,
    output logic [KEY_LEN-1:0]    data_out,
    output logic                  done,
    output logic                  busy,
    output logic [255:0]          hash_addr_updated,
    output logic                  hash_start,
    output logic [1023:0]         hash_data_in,
    output logic                  message_length,
    output logic                  store_intermediate,
    output logic                  continue_intermediate,
    input  logic                  hash_done,
    input  logic [KEY_LEN-1:0]    hash_data_out
);

    localparam logic [255:0] c_PRF_PAD = 256'(XMSS_HASH_PADDING_PRF);
    localparam logic [255:0] c_F_PAD   = 256'(XMSS_HASH_PADDING_F);
    localparam logic [255:0] c_ZERO    = '0;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CHECK     = 4'd1,
        S_REQ_KEY   = 4'd2,
        S_WAIT_KEY  = 4'd3,
        S_REQ_MASK  = 4'd4,
        S_WAIT_MASK = 4'd5,
        S_REQ_F     = 4'd6,
        S_WAIT_F    = 4'd7,
        S_FIN       = 4'd8
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [KEY_LEN-1:0]    r_seed;
    logic [KEY_LEN-1:0]    r_cur;
    logic [KEY_LEN-1:0]    r_fkey;
    logic [255:0]          r_addr;
    logic [WOTS_LOG_W-1:0] r_step;
    logic [WOTS_LOG_W-1:0] r_end_step;
    logic                  r_first;

    logic                  w_range_done;
    logic                  w_last_step;
    logic [255:0]          w_addr_key;
    logic [255:0]          w_addr_mask;

    assign message_length = 1'b0;
    assign w_range_done   = (r_step >= r_end_step);
    assign w_last_step    = (r_step == WOTS_LOG_W'(WOTS_W - 1));
    // Address word 6 carries the chain step, word 7 selects key (0) or mask (1).
    assign w_addr_key     = {r_addr[255:64], 32'(r_step), 32'd0};
    assign w_addr_mask    = {r_addr[255:32], 32'd1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (start) w_next_state = S_CHECK;
            S_CHECK:     w_next_state = w_range_done ? S_FIN : S_REQ_KEY;
            S_REQ_KEY:   w_next_state = S_WAIT_KEY;
            S_WAIT_KEY:  if (hash_done) w_next_state = S_REQ_MASK;
            S_REQ_MASK:  w_next_state = S_WAIT_MASK;
            S_WAIT_MASK: if (hash_done) w_next_state = S_REQ_F;
            S_REQ_F:     w_next_state = S_WAIT_F;
            S_WAIT_F:    if (hash_done) w_next_state = w_last_step ? S_FIN : S_CHECK;
            S_FIN:       w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out              <= '0;
            hash_addr_updated     <= '0;
            hash_data_in          <= '0;
            done                  <= 1'b0;
            busy                  <= 1'b0;
            hash_start            <= 1'b0;
            store_intermediate    <= 1'b0;
            continue_intermediate <= 1'b0;
            r_seed                <= '0;
            r_cur                 <= '0;
            r_fkey                <= '0;
            r_addr                <= '0;
            r_step                <= '0;
            r_end_step            <= '0;
            r_first               <= 1'b0;
        end else begin
            done                  <= 1'b0;
            hash_start            <= 1'b0;
            store_intermediate    <= 1'b0;
            continue_intermediate <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_seed     <= input_key;
                        r_cur      <= input_data;
                        r_step     <= start_step;
                        r_end_step <= end_step;
                        r_addr     <= hash_addr;
                        r_first    <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (w_range_done) begin
                        data_out          <= r_cur;
                        hash_addr_updated <= r_addr;
                        done              <= 1'b1;
                        busy              <= 1'b0;
                    end else begin
                        // The {PRF pad, seed} block is constant per request, so
                        // only the first PRF hashes it; later ones reuse core state.
                        r_addr                <= w_addr_key;
                        hash_start            <= 1'b1;
                        hash_data_in          <= {c_PRF_PAD, r_seed, w_addr_key, c_ZERO};
                        store_intermediate    <= r_first;
                        continue_intermediate <= ~r_first;
                        r_first               <= 1'b0;
                    end
                end
                S_WAIT_KEY: begin
                    if (hash_done) begin
                        r_fkey                <= hash_data_out;
                        r_addr                <= w_addr_mask;
                        hash_start            <= 1'b1;
                        hash_data_in          <= {c_PRF_PAD, r_seed, w_addr_mask, c_ZERO};
                        continue_intermediate <= 1'b1;
                    end
                end
                S_WAIT_MASK: begin
                    if (hash_done) begin
                        hash_start   <= 1'b1;
                        hash_data_in <= {c_F_PAD, r_fkey, r_cur ^ hash_data_out, c_ZERO};
                    end
                end
                S_WAIT_F: begin
                    if (hash_done) begin
                        r_cur  <= hash_data_out;
                        r_step <= r_step + WOTS_LOG_W'(1);
                        if (w_last_step) begin
                            data_out          <= hash_data_out;
                            hash_addr_updated <= r_addr;
                            done              <= 1'b1;
                            busy              <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wots_chain_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_wots_chain_engine
// Brief    : Self-checking bench; emulates the hash core and compares the
//            engine against a step-by-step chain model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wots_chain_engine;

    localparam int c_LIMIT = 8000;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [255:0]  input_key;
    logic [255:0]  input_data;
    logic [3:0]    start_step;
    logic [3:0]    end_step;
    logic [255:0]  hash_addr;
    logic [255:0]  data_out;
    logic          done;
    logic          busy;
    logic [255:0]  hash_addr_updated;
    logic          hash_start;
    logic [1023:0] hash_data_in;
    logic          message_length;
    logic          store_intermediate;
    logic          continue_intermediate;
    logic          hash_done;
    logic [255:0]  hash_data_out;

    wots_chain_engine dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .input_key             (input_key),
        .input_data            (input_data),
        .start_step            (start_step),
        .end_step              (end_step),
        .hash_addr             (hash_addr),
        .data_out              (data_out),
        .done                  (done),
        .busy                  (busy),
        .hash_addr_updated     (hash_addr_updated),
        .hash_start            (hash_start),
        .hash_data_in          (hash_data_in),
        .message_length        (message_length),
        .store_intermediate    (store_intermediate),
        .continue_intermediate (continue_intermediate),
        .hash_done             (hash_done),
        .hash_data_out         (hash_data_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Driver-owned expectations and control
    int            req_cnt = 0;
    int            aborted_cnt = 0;
    int            spur_cnt = 0;
    int            resp_delay = 1;
    bit            fixed_mode = 1'b0;
    logic [255:0]  fixed_resp [3];
    logic [1023:0] exp_msg [64];
    bit            exp_store [64];
    bit            exp_cont [64];
    int            exp_pulses;
    bit            exp_zero;
    logic [255:0]  exp_data;
    logic [255:0]  exp_addr;
    bit            lit_data_on = 1'b0;
    logic [255:0]  lit_data;
    int            lit_pulses = -1;
    int            lit_cont = -1;
    bit            lit_addr_on = 1'b0;
    logic [31:0]   lit_w6;
    logic [191:0]  lit_words05;
    bit            lit_fpay_on = 1'b0;
    logic [255:0]  lit_fpay;

    // Compare-process-owned
    int done_cnt = 0;

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // Stand-in hash: any message-dependent mixing works for the chain check.
    function automatic logic [255:0] model_hash(input logic [1023:0] m, input int idx);
        logic [255:0] a, b, c;
        if (fixed_mode) return fixed_resp[idx % 3];
        a = m[1023:768];
        b = m[767:512];
        c = m[511:256];
        return (a ^ {b[248:0], b[255:249]}) + {c[242:0], c[255:243]} + (c ^ {8{32'h9E3779B9}});
    endfunction

    task automatic build_expect(input logic [255:0] sd, input logic [255:0] dt,
                                input int s, input int e, input logic [255:0] ad);
        logic [255:0] cur, a, k, msk;
        int n;
        cur = dt;
        a   = ad;
        n   = 0;
        for (int i = s; i < e; i++) begin
            a[63:32] = 32'(i);
            a[31:0]  = 32'd0;
            exp_msg[n] = {256'd3, sd, a, 256'd0}; exp_store[n] = (n == 0); exp_cont[n] = (n != 0);
            k = model_hash(exp_msg[n], n); n++;
            a[31:0] = 32'd1;
            exp_msg[n] = {256'd3, sd, a, 256'd0}; exp_store[n] = 1'b0; exp_cont[n] = 1'b1;
            msk = model_hash(exp_msg[n], n); n++;
            exp_msg[n] = {256'd0, k, cur ^ msk, 256'd0}; exp_store[n] = 1'b0; exp_cont[n] = 1'b0;
            cur = model_hash(exp_msg[n], n); n++;
        end
        exp_pulses = n;
        exp_zero   = (s >= e);
        exp_data   = cur;
        exp_addr   = a;
    endtask

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hash-core emulation plus all output checks, once per cycle on the falling edge.
    initial begin : compare
        int seen_req, age, pidx, cont_seen, wait_cnt;
        bit outstanding, pending;
        logic [1023:0] msg;
        logic [255:0]  resp;
        int spur_seen;
        seen_req = 0; age = 0; pidx = 0; cont_seen = 0; wait_cnt = 0;
        outstanding = 1'b0; spur_seen = 0; resp = '0;
        hash_done = 1'b0;
        hash_data_out = '0;
        forever begin
            @(negedge clk);
            hash_done = 1'b0;
            if (req_cnt != seen_req) begin
                seen_req = req_cnt; age = 0; pidx = 0; cont_seen = 0;
            end else begin
                age++;
            end
            pending = (req_cnt - done_cnt - aborted_cnt) > 0;

            if (outstanding) begin
                if (!reset) chk("start_while_outstanding", 1024'(hash_start), 1024'(0));
                wait_cnt--;
                if (wait_cnt <= 0) begin
                    hash_done = 1'b1; hash_data_out = resp; outstanding = 1'b0;
                end
            end else if (hash_start && !reset) begin
                msg = hash_data_in;
                if (pidx < exp_pulses) begin
                    chk("hash_msg", msg, exp_msg[pidx]);
                    chk("store_flag", 1024'(store_intermediate), 1024'(exp_store[pidx]));
                    chk("continue_flag", 1024'(continue_intermediate), 1024'(exp_cont[pidx]));
                    if (lit_fpay_on && pidx == 2) chk("f_payload", 1024'(msg[511:256]), 1024'(lit_fpay));
                end else begin
                    chk("extra_hash_start", 1024'(pidx), 1024'(exp_pulses));
                end
                if (continue_intermediate) cont_seen++;
                resp = model_hash(msg, pidx);
                pidx++;
                outstanding = 1'b1;
                wait_cnt = (resp_delay == 0) ? int'($urandom_range(1, 4)) : resp_delay;
            end else if (spur_cnt != spur_seen) begin
                spur_seen = spur_cnt;
                hash_done = 1'b1;
                hash_data_out = rand256();
            end

            if (reset) begin
                chk("reset_outputs",
                    {data_out, hash_addr_updated, hash_data_in, done, busy, hash_start,
                     store_intermediate, continue_intermediate} == '0 ? 1024'(0) :
                    1024'({done, busy, hash_start, store_intermediate, continue_intermediate, 1'b1}),
                    1024'(0));
            end else if (done) begin
                if (!pending) begin
                    chk("unexpected_done", 1024'(done), 1024'(0));
                end else begin
                    chk("busy_at_done", 1024'(busy), 1024'(0));
                    chk("data_out", 1024'(data_out), 1024'(exp_data));
                    chk("hash_addr_updated", 1024'(hash_addr_updated), 1024'(exp_addr));
                    chk("hash_start_count", 1024'(pidx), 1024'(exp_pulses));
                    if (exp_zero) chk("zero_step_latency", 1024'(age), 1024'(1));
                    if (lit_data_on) chk("data_out_literal", 1024'(data_out), 1024'(lit_data));
                    if (lit_pulses >= 0) chk("pulses_literal", 1024'(pidx), 1024'(lit_pulses));
                    if (lit_cont >= 0) chk("continue_count", 1024'(cont_seen), 1024'(lit_cont));
                    if (lit_addr_on) begin
                        chk("final_word6", 1024'(hash_addr_updated[63:32]), 1024'(lit_w6));
                        chk("final_word7", 1024'(hash_addr_updated[31:0]), 1024'(1));
                        chk("addr_words0_5", 1024'(hash_addr_updated[255:64]), 1024'(lit_words05));
                    end
                    done_cnt++;
                end
            end else if (pending) begin
                chk("busy_during_request", 1024'(busy), 1024'(1));
                if (age > c_LIMIT) begin
                    chk("done_timeout", 1024'(pending), 1024'(0));
                    done_cnt++;
                end
            end else begin
                chk("idle_busy", 1024'(busy), 1024'(0));
            end
        end
    end

    task automatic issue(input logic [255:0] sd, input logic [255:0] dt, input int s,
                         input int e, input logic [255:0] ad);
        build_expect(sd, dt, s, e, ad);
        @(negedge clk); #1;
        input_key  = sd;
        input_data = dt;
        start_step = 4'(s);
        end_step   = 4'(e);
        hash_addr  = ad;
        start      = 1'b1;
        req_cnt++;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        while ((req_cnt - done_cnt - aborted_cnt) > 0) @(negedge clk);
    endtask

    task automatic clear_lits();
        lit_data_on = 1'b0; lit_pulses = -1; lit_cont = -1; lit_addr_on = 1'b0; lit_fpay_on = 1'b0;
    endtask

    logic [255:0] seed, addr;
    logic [191:0] words05;

    initial begin : driver
        int cnt;
        reset = 1'b1; start = 1'b0;
        input_key = '0; input_data = '0; start_step = '0; end_step = '0; hash_addr = '0;
        fixed_resp[0] = {8{32'h4B4B4B4B}};
        fixed_resp[1] = {8{32'hFFFF0000}};
        fixed_resp[2] = {8{32'hF00DF00D}};
        words05 = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 32'h66666666};
        seed = rand256();
        addr = {words05, $urandom, $urandom};
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        // Zero-step request
        lit_data_on = 1'b1; lit_data = {32{8'hA5}}; lit_pulses = 0;
        issue(seed, {32{8'hA5}}, 3, 3, addr);
        wait_idle(); clear_lits();

        // Single step with fixed hash responses K, M, F
        fixed_mode = 1'b1; resp_delay = 2;
        lit_data_on = 1'b1; lit_data = {8{32'hF00DF00D}}; lit_pulses = 3;
        lit_fpay_on = 1'b1; lit_fpay = {8{32'hF0F00F0F}};
        issue(seed, {8{32'h0F0F0F0F}}, 0, 1, addr);
        wait_idle(); clear_lits(); fixed_mode = 1'b0;

        // Full range 0..15
        resp_delay = 1;
        lit_pulses = 45; lit_cont = 29; lit_addr_on = 1'b1; lit_w6 = 32'd14; lit_words05 = words05;
        issue(rand256(), rand256(), 0, 15, addr);
        wait_idle(); clear_lits();

        // Same request with fast and slow hash core; stray hash_done while idle
        seed = rand256();
        resp_delay = 1;
        issue(seed, {8{32'hC0FFEE00}}, 2, 5, addr);
        wait_idle();
        spur_cnt++;
        repeat (5) @(negedge clk);
        resp_delay = 80;
        issue(seed, {8{32'hC0FFEE00}}, 2, 5, addr);
        repeat (6) @(negedge clk);
        #1 input_data = '1; start_step = 4'd0; end_step = 4'd9; start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        wait_idle();

        // Reset while waiting for the mask; the late hash_done must be ignored
        resp_delay = 20;
        issue(rand256(), rand256(), 0, 4, addr);
        cnt = 0;
        for (int t = 0; t < 500 && cnt < 2; t++) begin
            @(negedge clk);
            if (hash_start) cnt++;
        end
        @(posedge clk); #2;
        reset = 1'b1;
        aborted_cnt++;
        @(negedge clk); @(negedge clk); #1 reset = 1'b0;
        repeat (40) @(negedge clk);
        resp_delay = 1;
        lit_addr_on = 1'b1; lit_w6 = 32'd2; lit_words05 = words05;
        issue(rand256(), rand256(), 1, 3, addr);
        wait_idle(); clear_lits();

        // Randomized requests
        resp_delay = 0;
        for (int r = 0; r < 10; r++) begin
            issue(rand256(), rand256(), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  {words05, $urandom, $urandom});
            wait_idle();
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
